// File: rtl/jt900h_prefetch_if.sv
// Program-memory read port between the prefetch queue (master) and memory (slave).
interface jt900h_prefetch_if;
   logic [23:0] bus_addr;
   logic        bus_rd;
   logic [15:0] bus_din;
   logic        bus_ok;

   modport master (output bus_addr, output bus_rd, input bus_din, input bus_ok);
   modport slave  (input bus_addr, input bus_rd, output bus_din, output bus_ok);
endinterface

// File: rtl/jt900h_prefetch.sv
// Byte-wide instruction prefetch FIFO fed by 16-bit memory reads; exposes the
// next four opcode bytes at pc and retires 0-3 bytes per enabled cycle.
module jt900h_prefetch #(
   parameter int DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cen,
   input  logic              pc_load,
   input  logic [23:0]       pc_in,
   input  logic [1:0]        fetched,
   output logic [31:0]       op,
   output logic              op_ok,
   output logic [23:0]       pc,
   jt900h_prefetch_if.master bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [7:0]    buf_q [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [PW-1:0] rd1, rd2, rd3, wr1;
   logic [CW-1:0] cnt, cnt_n;
   logic [23:0]   fa, fa_n;
   logic          drop;
   logic          accept;
   logic [1:0]    pushed, popped;
   logic          issue;

   always_comb begin
      accept = bus.bus_rd & bus.bus_ok;
      pushed = 2'd0;
      if (accept && !drop)
         pushed = fa[0] ? 2'd1 : 2'd2;
      popped = op_ok ? fetched : 2'd0;
      cnt_n  = cnt + CW'(pushed) - CW'(popped);
      fa_n   = fa + 24'(pushed);
      // A read completing this cycle frees the port for the next request
      issue  = (!bus.bus_rd || accept) && !drop && (cnt_n <= CW'(DEPTH - 2));
      rd1    = rd_ptr + PW'(1);
      rd2    = rd_ptr + PW'(2);
      rd3    = rd_ptr + PW'(3);
      wr1    = wr_ptr + PW'(1);
      op     = {buf_q[rd3], buf_q[rd2], buf_q[rd1], buf_q[rd_ptr]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc           <= 24'd0;
         fa           <= 24'd0;
         cnt          <= '0;
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         op_ok        <= 1'b0;
         bus.bus_rd   <= 1'b0;
         bus.bus_addr <= 24'd0;
         drop         <= 1'b0;
         for (int i = 0; i < DEPTH; i++)
            buf_q[i] <= 8'd0;
      end else if (cen) begin
         if (pc_load) begin
            pc     <= pc_in;
            fa     <= pc_in;
            cnt    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            op_ok  <= 1'b0;
            // An unfinished read must still complete on the bus; its data is discarded
            if (accept) begin
               bus.bus_rd <= 1'b0;
               drop       <= 1'b0;
            end else if (bus.bus_rd) begin
               drop <= 1'b1;
            end
         end else if (drop) begin
            if (accept) begin
               bus.bus_rd <= 1'b0;
               drop       <= 1'b0;
            end
         end else begin
            if (pushed == 2'd1) begin
               buf_q[wr_ptr] <= bus.bus_din[15:8];
               wr_ptr        <= wr1;
            end else if (pushed == 2'd2) begin
               buf_q[wr_ptr] <= bus.bus_din[7:0];
               buf_q[wr1]    <= bus.bus_din[15:8];
               wr_ptr        <= wr_ptr + PW'(2);
            end
            rd_ptr <= rd_ptr + PW'(popped);
            pc     <= pc + 24'(popped);
            cnt    <= cnt_n;
            fa     <= fa_n;
            op_ok  <= (cnt_n >= CW'(4));
            if (issue) begin
               bus.bus_rd   <= 1'b1;
               bus.bus_addr <= {fa_n[23:1], 1'b0};
            end else if (accept) begin
               bus.bus_rd <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_jt900h_prefetch.sv
// Randomized bench for jt900h_prefetch: byte-stream reference model plus directed scenarios.
module tb_jt900h_prefetch;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cen = 1'b0;
   logic        pc_load = 1'b0;
   logic [23:0] pc_in = 24'd0;
   logic [1:0]  fetched = 2'd0;
   logic [31:0] op;
   logic        op_ok;
   logic [23:0] pc;

   jt900h_prefetch_if bus ();

   jt900h_prefetch #(.DEPTH(DEPTH)) dut (
      .clk     (clk),
      .rst     (rst),
      .cen     (cen),
      .pc_load (pc_load),
      .pc_in   (pc_in),
      .fetched (fetched),
      .op      (op),
      .op_ok   (op_ok),
      .pc      (pc),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Program memory: a few fixed bytes, the rest a deterministic address hash
   logic [7:0] ov [logic [23:0]];

   function automatic logic [7:0] mb(input logic [23:0] a);
      if (ov.exists(a)) return ov[a];
      return a[7:0] ^ {a[12:8], a[15:13]} ^ a[23:16] ^ 8'h5A;
   endfunction

   // Memory responder: bus_ok after wait_n enabled cycles of a pending read
   int wait_n = 0;
   int wcnt   = 0;
   initial begin
      bus.bus_ok  = 1'b0;
      bus.bus_din = 16'd0;
      forever begin
         @(negedge clk);
         if (!bus.bus_rd) begin
            bus.bus_ok = 1'b0;
            wcnt = 0;
         end else if (wcnt >= wait_n) begin
            bus.bus_ok  = 1'b1;
            bus.bus_din = {mb(bus.bus_addr + 24'd1), mb(bus.bus_addr)};
         end else begin
            bus.bus_ok  = 1'b0;
            bus.bus_din = 16'($urandom);
            if (cen) wcnt++;
         end
         if (bus.bus_ok && cen && !rst) wcnt = 0;
      end
   end

   // Reference model: queue of program bytes starting at m_pc
   logic [23:0] m_pc = 24'd0, m_fa = 24'd0, m_addr = 24'd0;
   logic        m_rd = 1'b0, m_stale = 1'b0;
   logic [7:0]  mq [$];
   logic        s_rst, s_cen, s_load, s_rd, s_ok, acc, m_ok;
   logic [23:0] s_pcin;
   logic [1:0]  s_f;

   initial begin
      forever begin
         @(negedge clk);
         #3;
         s_rst = rst; s_cen = cen; s_load = pc_load; s_pcin = pc_in; s_f = fetched;
         s_rd = bus.bus_rd; s_ok = bus.bus_ok;
         m_ok = (mq.size() >= 4);
         if (s_rst) begin
            m_pc = 24'd0; m_fa = 24'd0; m_addr = 24'd0; m_rd = 1'b0; m_stale = 1'b0;
            mq.delete();
         end else if (s_cen) begin
            acc = s_rd && s_ok;
            if (s_load) begin
               m_pc = s_pcin; m_fa = s_pcin;
               mq.delete();
               if (acc) begin
                  m_rd = 1'b0; m_stale = 1'b0;
               end else if (s_rd) begin
                  m_stale = 1'b1;
               end
            end else if (m_stale) begin
               if (acc) begin
                  m_rd = 1'b0; m_stale = 1'b0;
               end
            end else begin
               if (acc) begin
                  mq.push_back(mb(m_fa));
                  if (m_fa[0]) m_fa = m_fa + 24'd1;
                  else begin
                     mq.push_back(mb(m_fa + 24'd1));
                     m_fa = m_fa + 24'd2;
                  end
               end
               if (m_ok)
                  for (int i = 0; i < int'(s_f); i++) begin
                     void'(mq.pop_front());
                     m_pc = m_pc + 24'd1;
                  end
               if ((!s_rd || acc) && mq.size() <= DEPTH - 2) begin
                  m_rd = 1'b1;
                  m_addr = {m_fa[23:1], 1'b0};
               end else if (acc) begin
                  m_rd = 1'b0;
               end
            end
         end
         @(posedge clk);
         #1;
         check("bus_rd", 32'(bus.bus_rd), 32'(m_rd));
         if (m_rd) check("bus_addr", 32'(bus.bus_addr), 32'(m_addr));
         check("op_ok", 32'(op_ok), 32'(mq.size() >= 4));
         check("pc", 32'(pc), 32'(m_pc));
         if (mq.size() >= 4) check("op", op, {mq[3], mq[2], mq[1], mq[0]});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [23:0] a);
      pc_load = 1'b1;
      pc_in   = a;
      tick();
      pc_load = 1'b0;
   endtask

   task automatic wait_ok(input string tag, input int max);
      int k = 0;
      while (!op_ok && k < max) begin
         tick();
         k++;
      end
      check(tag, 32'(op_ok), 32'd1);
   endtask

   initial begin
      logic [23:0] start;
      int k;
      ov[24'h000100] = 8'hB1; ov[24'h000101] = 8'hA0;
      ov[24'h000102] = 8'hD3; ov[24'h000103] = 8'hC2;

      repeat (3) tick();
      rst = 1'b0;
      check("rst_op_ok", 32'(op_ok), 32'd0);
      check("rst_pc", 32'(pc), 32'd0);
      check("rst_bus_rd", 32'(bus.bus_rd), 32'd0);
      check("rst_bus_addr", 32'(bus.bus_addr), 32'd0);
      check("rst_op", op, 32'd0);
      cen = 1'b1;

      // Even start, zero-wait memory
      do_load(24'h000100);
      wait_ok("t1_wait", 20);
      check("t1_op", op, 32'hC2D3A0B1);
      check("t1_pc", 32'(pc), 32'h000100);

      // Odd start: first read yields only the odd byte
      do_load(24'h000101);
      wait_ok("t2_wait", 20);
      check("t2_op0", 32'(op[7:0]), 32'hA0);
      check("t2_op1", 32'(op[15:8]), 32'hD3);
      check("t2_op2", 32'(op[23:16]), 32'hC2);

      // Steady stream consuming 3 bytes per cycle
      start = 24'h001000;
      do_load(start);
      fetched = 2'd3;
      k = 0;
      while (pc - start < 24'd64 && k < 300) begin
         tick();
         k++;
      end
      fetched = 2'd0;
      check("t3_progress", 32'(pc - start >= 24'd64), 32'd1);

      // Jump while a slow read of 0x104 is outstanding
      wait_n = 3;
      do_load(24'h000100);
      k = 0;
      while (!(bus.bus_rd && bus.bus_addr == 24'h000104) && k < 60) begin
         tick();
         k++;
      end
      check("t4_issue", 32'(bus.bus_addr), 32'h000104);
      do_load(24'h000200);
      k = 0;
      while (!(bus.bus_rd && bus.bus_addr != 24'h000104) && k < 30) begin
         tick();
         k++;
      end
      check("t4_next_addr", 32'(bus.bus_addr), 32'h000200);
      wait_ok("t4_wait", 40);
      check("t4_op0", 32'(op[7:0]), 32'(mb(24'h000200)));

      // Full queue stops requests until bytes are consumed
      wait_n = 0;
      do_load(24'h000300);
      repeat (14) tick();
      check("t5_full_rd", 32'(bus.bus_rd), 32'd0);
      check("t5_full_ok", 32'(op_ok), 32'd1);
      fetched = 2'd2;
      tick();
      fetched = 2'd0;
      check("t5_reissue", 32'(bus.bus_rd), 32'd1);
      check("t5_addr", 32'(bus.bus_addr), 32'h000308);
      check("t5_pc", 32'(pc), 32'h000302);

      // Address wrap at the top of memory
      do_load(24'hFFFFFE);
      wait_ok("t6_wait", 20);
      check("t6_op", op, {mb(24'h000001), mb(24'h000000), mb(24'hFFFFFF), mb(24'hFFFFFE)});
      fetched = 2'd2;
      tick();
      fetched = 2'd0;
      check("t6_pc", 32'(pc), 32'h000000);

      // Reset in the middle of a read
      wait_n = 3;
      do_load(24'h000400);
      k = 0;
      while (!bus.bus_rd && k < 10) begin
         tick();
         k++;
      end
      check("t6_rd_pending", 32'(bus.bus_rd), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6_rst_rd", 32'(bus.bus_rd), 32'd0);
      check("t6_rst_ok", 32'(op_ok), 32'd0);
      check("t6_rst_pc", 32'(pc), 32'd0);
      check("t6_rst_op", op, 32'd0);

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         cen     = ($urandom_range(0, 4) != 0);
         fetched = 2'($urandom_range(0, 3));
         pc_load = ($urandom_range(0, 39) == 0);
         case ($urandom_range(0, 2))
            0: pc_in = 24'($urandom);
            1: pc_in = 24'hFFFFF0 | 24'($urandom_range(0, 15));
            default: pc_in = 24'($urandom_range(0, 255));
         endcase
         if ($urandom_range(0, 15) == 0) wait_n = $urandom_range(0, 3);
         tick();
      end
      pc_load = 1'b0;
      fetched = 2'd0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
